jtkunio_colmix: RTL and testbench
=================================

# jtkunio_colmix

Colour mixer for the Kunio video pipeline, fed by the object line buffer, the scroll layer and the character layer. It resolves layer priority per pixel and builds a palette index. It reads a CPU-writable palette RAM and drives blanked 4-4-4 RGB together with delayed blanking signals for the frame's video output. It sits directly downstream of the object renderer's 5-bit pixel output.

## Interface
Parameters:
- `BLANK_DLY`, 2: pixel-enable delay applied to `LHBL`/`LVBL`; must equal the pixel-path latency.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  synchronous, active-low reset; one clock, sampled on `clk` rising edge
- `pxl_cen`  in  1  pixel clock enable; asserted at most every second `clk` cycle
- `LHBL`  in  1  horizontal blank, active low
- `LVBL`  in  1  vertical blank, active low
- `char_pxl`  in  5  {pal[1:0], colour[2:0]}
- `obj_pxl`  in  5  {pal[1:0], colour[2:0]}, from the object buffer
- `scr_pxl`  in  6  {pal[2:0], colour[2:0]}
- `gfx_en`  in  3  debug layer enables: bit0 char, bit1 scroll, bit2 obj
- `cpu_addr`  in  9  bit8 = bank (0: R/G byte, 1: B nibble), bits[7:0] = entry
- `pal_cs`  in  1  palette chip select
- `cpu_wrn`  in  1  write strobe, active low
- `cpu_dout`  in  8  CPU write data
- `cpu_din`  out  8  read data; bank1 returns {4'hF, B}
- `red`, `green`, `blue`  out  4 each  colour output
- `LHBL_dly`, `LVBL_dly`  out  1 each  delayed blanking

## Operation
- Transparency: a layer is transparent when `colour[2:0]==0` or its `gfx_en` bit is 0. Scroll is never transparent unless disabled.
- Priority: char over obj over scroll.
- Palette index (8 bits):
  - char → {3'b000, char_pxl}
  - obj → {3'b100, obj_pxl}
  - scroll → {2'b11, scr_pxl}
  - all disabled → 8'h00
- Palette RAM: two 256-entry banks. Bank0 holds {R[3:0], G[3:0]}. Bank1 holds {4'h0, B[3:0]}, and only the low nibble is stored.
- CPU write: `pal_cs & ~cpu_wrn` writes `cpu_dout` to the selected bank on that clock.
  - Bank1 keeps bits[3:0] only.
  - Writes are allowed at any time, including active display. A pixel reading the same entry in the same clock gets the old value.
- CPU read: `cpu_din` is registered and valid one clock after the address is presented.
- Blanking: when delayed `LHBL` or `LVBL` is 0, RGB is forced to 0.
- Reset (`rst_n`=0):
  - `red`, `green`, `blue`, `LHBL_dly`, `LVBL_dly` and the pipeline registers clear to 0.
  - `cpu_din` clears to 0.
  - Palette contents are not cleared.
  - Reset mid-line discards in-flight pixels; the first valid pixel appears 2 `pxl_cen` after release.

## Timing
- Stage 1, on `pxl_cen`: priority mux registers `pal_idx`.
- Stage 2, next `clk`: RAM read of `pal_idx` from both banks (registered output).
- Stage 3, next `pxl_cen`: RGB registered with blanking applied.
- Total latency from input pixel to RGB: exactly 2 `pxl_cen` edges. `LHBL_dly`/`LVBL_dly` use a `BLANK_DLY`-deep shift register clocked by `pxl_cen`, so blanking aligns with RGB.
- With no `pxl_cen`, all outputs hold.
- The `pxl_cen` spacing of at least 2 clocks guarantees the RAM output settles before stage 3.
- Outputs are stable between `pxl_cen` edges. Outputs change only on a clock with `pxl_cen`=1, or in the clock where reset is asserted.

## Structure
- Shared package (`jtkunio_pkg`) holds:
  - layer base constants: `PAL_CHAR`=3'b000, `PAL_OBJ`=3'b100, `PAL_SCR`=2'b11
  - the transparent-colour value
  - the `gfx_en` bit positions
- Palette storage uses two `jtframe_dual_ram` instances (aw=8, dw=8 and dw=4). Port 0 is the CPU; port 1 is the pixel read.
- One natural sub-module: `jtkunio_prio`, the combinational priority/index mux, isolated for unit testing. Everything else stays in this file.

## Test plan
- Write bank0[0x85]=0xA3 and bank1[0x85]=0x0C. Drive `obj_pxl`=5'h05 and `char_pxl`=0, display active → after 2 `pxl_cen`, RGB = A,3,C.
- `char_pxl`=5'h01 and `obj_pxl`=5'h05 together → index 0x01 is used. Then set `gfx_en`[0]=0 → index 0x85.
- All three layers transparent and `scr_pxl`=6'h08 → index 0xC8. With `gfx_en`=0 → index 0x00.
- `LHBL` low for 1 pixel during active colour → RGB=0 on exactly the pixel aligned with `LHBL_dly`=0, 2 `pxl_cen` later.
- CPU writes bank1[0x10]=0xF7, then reads it back → `cpu_din`=0xF7 one clock after the read address.
- Assert `rst_n`=0 for 1 clock mid-line → all outputs 0 next clock. After release, the first non-zero RGB appears exactly 2 `pxl_cen` later, and palette contents are preserved.

Source files
------------

// File: rtl/jtkunio_pkg.sv
// Shared constants for the Kunio colour mixer: palette layer bases,
// the transparent colour code and the debug layer-enable bit positions.
package jtkunio_pkg;

    localparam logic [2:0] PAL_CHAR   = 3'b000;
    localparam logic [2:0] PAL_OBJ    = 3'b100;
    localparam logic [1:0] PAL_SCR    = 2'b11;

    localparam logic [2:0] COL_TRANSP = 3'd0;

    localparam int GFX_CHAR = 0;
    localparam int GFX_SCR  = 1;
    localparam int GFX_OBJ  = 2;

    typedef enum logic [1:0] {
        LAYER_NONE,
        LAYER_SCR,
        LAYER_OBJ,
        LAYER_CHAR
    } layer_e;

    function automatic logic is_opaque(input logic [2:0] col, input logic en);
        return en && (col != COL_TRANSP);
    endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// Single-clock dual-port RAM with registered read on both ports.
// Reads return the contents from before any write in the same clock.
module jtframe_dual_ram #(
    parameter int dw = 8,
    parameter int aw = 8
) (
    input  logic          clk,
    input  logic [dw-1:0] data0,
    input  logic [aw-1:0] addr0,
    input  logic          we0,
    output logic [dw-1:0] q0,
    input  logic [dw-1:0] data1,
    input  logic [aw-1:0] addr1,
    input  logic          we1,
    output logic [dw-1:0] q1
);

    logic [dw-1:0] mem [0:2**aw-1];

    // Port 0 wins if both ports write the same clock.
    always_ff @(posedge clk) begin
        q0 <= mem[addr0];
        q1 <= mem[addr1];
        if (we0) begin
            mem[addr0] <= data0;
        end else if (we1) begin
            mem[addr1] <= data1;
        end
    end

endmodule

// File: rtl/jtkunio_prio.sv
// Combinational layer priority (char > obj > scroll) and palette index builder.
module jtkunio_prio
    import jtkunio_pkg::*;
(
    input  logic [4:0] char_pxl,
    input  logic [4:0] obj_pxl,
    input  logic [5:0] scr_pxl,
    input  logic [2:0] gfx_en,
    output logic [7:0] pal_idx
);

    layer_e layer;

    // Scroll has no transparent colour; only its enable can hide it.
    always_comb begin
        layer = LAYER_NONE;
        if (is_opaque(char_pxl[2:0], gfx_en[GFX_CHAR])) begin
            layer = LAYER_CHAR;
        end else if (is_opaque(obj_pxl[2:0], gfx_en[GFX_OBJ])) begin
            layer = LAYER_OBJ;
        end else if (gfx_en[GFX_SCR]) begin
            layer = LAYER_SCR;
        end
    end

    always_comb begin
        pal_idx = 8'h00;
        unique case (layer)
            LAYER_CHAR: pal_idx = {PAL_CHAR, char_pxl};
            LAYER_OBJ:  pal_idx = {PAL_OBJ, obj_pxl};
            LAYER_SCR:  pal_idx = {PAL_SCR, scr_pxl};
            default:    pal_idx = 8'h00;
        endcase
    end

endmodule

// File: rtl/jtkunio_colmix.sv
// Kunio colour mixer: priority mux, CPU-writable palette RAM and blanked
// 4-4-4 RGB output with blanking delayed to match the pixel path.
module jtkunio_colmix
    import jtkunio_pkg::*;
#(
    parameter int BLANK_DLY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pxl_cen,
    input  logic       LHBL,
    input  logic       LVBL,
    input  logic [4:0] char_pxl,
    input  logic [4:0] obj_pxl,
    input  logic [5:0] scr_pxl,
    input  logic [2:0] gfx_en,
    input  logic [8:0] cpu_addr,
    input  logic       pal_cs,
    input  logic       cpu_wrn,
    input  logic [7:0] cpu_dout,
    output logic [7:0] cpu_din,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       LHBL_dly,
    output logic       LVBL_dly
);

    logic [7:0]           mux_idx;
    logic [7:0]           pal_idx_d, pal_idx_q;
    logic [7:0]           pxl_rg, cpu_rg;
    logic [3:0]           pxl_b, cpu_b;
    logic                 we_rg, we_b;
    logic [BLANK_DLY-1:0] lhbl_sr_d, lhbl_sr_q;
    logic [BLANK_DLY-1:0] lvbl_sr_d, lvbl_sr_q;
    logic                 blank;
    logic [3:0]           red_d, red_q, green_d, green_q, blue_d, blue_q;
    logic                 rd_bank_d, rd_bank_q, rd_valid_d, rd_valid_q;

    jtkunio_prio u_prio (
        .char_pxl (char_pxl),
        .obj_pxl  (obj_pxl),
        .scr_pxl  (scr_pxl),
        .gfx_en   (gfx_en),
        .pal_idx  (mux_idx)
    );

    assign we_rg = pal_cs & ~cpu_wrn & ~cpu_addr[8];
    assign we_b  = pal_cs & ~cpu_wrn &  cpu_addr[8];

    jtframe_dual_ram #(.dw(8), .aw(8)) u_ram_rg (
        .clk   (clk),
        .data0 (cpu_dout),
        .addr0 (cpu_addr[7:0]),
        .we0   (we_rg),
        .q0    (cpu_rg),
        .data1 (8'h00),
        .addr1 (pal_idx_q),
        .we1   (1'b0),
        .q1    (pxl_rg)
    );

    jtframe_dual_ram #(.dw(4), .aw(8)) u_ram_b (
        .clk   (clk),
        .data0 (cpu_dout[3:0]),
        .addr0 (cpu_addr[7:0]),
        .we0   (we_b),
        .q0    (cpu_b),
        .data1 (4'h0),
        .addr1 (pal_idx_q),
        .we1   (1'b0),
        .q1    (pxl_b)
    );

    // Blanking uses the value LHBL_dly/LVBL_dly take on this same edge.
    always_comb begin
        pal_idx_d = pal_idx_q;
        lhbl_sr_d = lhbl_sr_q;
        lvbl_sr_d = lvbl_sr_q;
        red_d     = red_q;
        green_d   = green_q;
        blue_d    = blue_q;
        if (pxl_cen) begin
            pal_idx_d = mux_idx;
            lhbl_sr_d = {lhbl_sr_q[BLANK_DLY-2:0], LHBL};
            lvbl_sr_d = {lvbl_sr_q[BLANK_DLY-2:0], LVBL};
        end
        blank = ~(lhbl_sr_d[BLANK_DLY-1] & lvbl_sr_d[BLANK_DLY-1]);
        if (pxl_cen) begin
            red_d   = blank ? 4'h0 : pxl_rg[7:4];
            green_d = blank ? 4'h0 : pxl_rg[3:0];
            blue_d  = blank ? 4'h0 : pxl_b;
        end
    end

    always_comb begin
        rd_bank_d  = cpu_addr[8];
        rd_valid_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pal_idx_q  <= '0;
            lhbl_sr_q  <= '0;
            lvbl_sr_q  <= '0;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
            rd_bank_q  <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            pal_idx_q  <= pal_idx_d;
            lhbl_sr_q  <= lhbl_sr_d;
            lvbl_sr_q  <= lvbl_sr_d;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
            rd_bank_q  <= rd_bank_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign cpu_din  = rd_valid_q ? (rd_bank_q ? {4'hF, cpu_b} : cpu_rg) : 8'h00;
    assign red      = red_q;
    assign green    = green_q;
    assign blue     = blue_q;
    assign LHBL_dly = lhbl_sr_q[BLANK_DLY-1];
    assign LVBL_dly = lvbl_sr_q[BLANK_DLY-1];

endmodule

// File: tb/tb_jtkunio_colmix.sv
// Directed bench for jtkunio_colmix: palette access, layer priority,
// pixel latency, blanking alignment, output hold and mid-line reset.
module tb_jtkunio_colmix;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       pxl_cen  = 1'b0;
    logic       LHBL     = 1'b1;
    logic       LVBL     = 1'b1;
    logic [4:0] char_pxl = '0;
    logic [4:0] obj_pxl  = '0;
    logic [5:0] scr_pxl  = '0;
    logic [2:0] gfx_en   = 3'b111;
    logic [8:0] cpu_addr = '0;
    logic       pal_cs   = 1'b0;
    logic       cpu_wrn  = 1'b1;
    logic [7:0] cpu_dout = '0;
    logic [7:0] cpu_din;
    logic [3:0] red, green, blue;
    logic       LHBL_dly, LVBL_dly;
    logic [11:0] rgb_obs;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign rgb_obs = {red, green, blue};

    jtkunio_colmix #(.BLANK_DLY(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pxl_cen  (pxl_cen),
        .LHBL     (LHBL),
        .LVBL     (LVBL),
        .char_pxl (char_pxl),
        .obj_pxl  (obj_pxl),
        .scr_pxl  (scr_pxl),
        .gfx_en   (gfx_en),
        .cpu_addr (cpu_addr),
        .pal_cs   (pal_cs),
        .cpu_wrn  (cpu_wrn),
        .cpu_dout (cpu_dout),
        .cpu_din  (cpu_din),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .LHBL_dly (LHBL_dly),
        .LVBL_dly (LVBL_dly)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One pixel: pxl_cen high for a single clock, then two idle clocks.
    task automatic pixel();
        pxl_cen = 1'b1;
        step();
        pxl_cen = 1'b0;
        step();
        step();
    endtask

    task automatic cpu_write(input logic [8:0] a, input logic [7:0] d);
        cpu_addr = a;
        cpu_dout = d;
        pal_cs   = 1'b1;
        cpu_wrn  = 1'b0;
        step();
        pal_cs   = 1'b0;
        cpu_wrn  = 1'b1;
    endtask

    task automatic load_palette();
        cpu_write(9'h085, 8'hA3);
        cpu_write(9'h185, 8'h0C);
        cpu_write(9'h001, 8'h12);
        cpu_write(9'h101, 8'h04);
        cpu_write(9'h0C8, 8'h56);
        cpu_write(9'h1C8, 8'h09);
        cpu_write(9'h000, 8'h7E);
        cpu_write(9'h100, 8'h0B);
        cpu_write(9'h110, 8'hF7);
        cpu_write(9'h111, 8'h3A);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_checks++;
        if (rgb_obs !== 12'h000) begin
            n_fail++;
            $display("[TB] FAIL reset_rgb: got %h expected %h", rgb_obs, 12'h000);
        end
        n_checks++;
        if (LHBL_dly !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_lhbl_dly: got %b expected 0", LHBL_dly);
        end
        n_checks++;
        if (LVBL_dly !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_lvbl_dly: got %b expected 0", LVBL_dly);
        end
        n_checks++;
        if (cpu_din !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_cpu_din: got %h expected 00", cpu_din);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_cpu_readback();
        logic [8:0] addrs [5];
        logic [7:0] exps  [5];
        addrs = '{9'h110, 9'h111, 9'h085, 9'h185, 9'h100};
        exps  = '{8'hF7,  8'hFA,  8'hA3,  8'hFC,  8'hFB};
        for (int i = 0; i < 5; i++) begin
            cpu_addr = addrs[i];
            step();
            n_checks++;
            if (cpu_din !== exps[i]) begin
                n_fail++;
                $display("[TB] FAIL cpu_read[%h]: got %h expected %h", addrs[i], cpu_din, exps[i]);
            end
        end
    endtask

    typedef struct {
        logic [4:0]  c;
        logic [4:0]  o;
        logic [5:0]  s;
        logic [2:0]  g;
        logic [11:0] rgb;
    } prio_vec_t;

    // Each vector is held for two pixels: the first shows the previous
    // vector's colour (two-edge latency), the second shows the new one.
    task automatic test_priority();
        prio_vec_t vecs [9];
        logic [11:0] prev;
        vecs = '{
            '{5'h00, 5'h05, 6'h00, 3'b111, 12'hA3C},
            '{5'h01, 5'h05, 6'h00, 3'b111, 12'h124},
            '{5'h01, 5'h05, 6'h00, 3'b110, 12'hA3C},
            '{5'h18, 5'h05, 6'h00, 3'b111, 12'hA3C},
            '{5'h00, 5'h00, 6'h08, 3'b111, 12'h569},
            '{5'h00, 5'h10, 6'h08, 3'b111, 12'h569},
            '{5'h01, 5'h05, 6'h08, 3'b010, 12'h569},
            '{5'h01, 5'h05, 6'h08, 3'b000, 12'h7EB},
            '{5'h00, 5'h00, 6'h08, 3'b001, 12'h7EB}
        };
        prev = 12'h000;
        for (int i = 0; i < 9; i++) begin
            char_pxl = vecs[i].c;
            obj_pxl  = vecs[i].o;
            scr_pxl  = vecs[i].s;
            gfx_en   = vecs[i].g;
            pixel();
            n_checks++;
            if (rgb_obs !== prev) begin
                n_fail++;
                $display("[TB] FAIL prio_latency[%0d]: got %h expected %h", i, rgb_obs, prev);
            end
            pixel();
            n_checks++;
            if (rgb_obs !== vecs[i].rgb) begin
                n_fail++;
                $display("[TB] FAIL prio_rgb[%0d]: got %h expected %h", i, rgb_obs, vecs[i].rgb);
            end
            prev = vecs[i].rgb;
        end
    endtask

    task automatic test_blanking();
        logic hb [8];
        logic vb [8];
        logic prev_h, prev_v;
        logic [11:0] exp_rgb;
        hb = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        char_pxl = 5'h00;
        obj_pxl  = 5'h05;
        scr_pxl  = 6'h00;
        gfx_en   = 3'b111;
        LHBL     = 1'b1;
        LVBL     = 1'b1;
        pixel();
        pixel();
        prev_h = 1'b1;
        prev_v = 1'b1;
        for (int i = 0; i < 8; i++) begin
            LHBL = hb[i];
            LVBL = vb[i];
            pixel();
            exp_rgb = (prev_h && prev_v) ? 12'hA3C : 12'h000;
            n_checks++;
            if (rgb_obs !== exp_rgb) begin
                n_fail++;
                $display("[TB] FAIL blank_rgb[%0d]: got %h expected %h", i, rgb_obs, exp_rgb);
            end
            n_checks++;
            if (LHBL_dly !== prev_h) begin
                n_fail++;
                $display("[TB] FAIL lhbl_dly[%0d]: got %b expected %b", i, LHBL_dly, prev_h);
            end
            n_checks++;
            if (LVBL_dly !== prev_v) begin
                n_fail++;
                $display("[TB] FAIL lvbl_dly[%0d]: got %b expected %b", i, LVBL_dly, prev_v);
            end
            prev_h = hb[i];
            prev_v = vb[i];
        end
        LHBL = 1'b1;
        LVBL = 1'b1;
    endtask

    task automatic test_hold();
        char_pxl = 5'h01;
        repeat (6) step();
        n_checks++;
        if (rgb_obs !== 12'hA3C) begin
            n_fail++;
            $display("[TB] FAIL hold_rgb: got %h expected %h", rgb_obs, 12'hA3C);
        end
        pixel();
        n_checks++;
        if (rgb_obs !== 12'hA3C) begin
            n_fail++;
            $display("[TB] FAIL hold_first_edge: got %h expected %h", rgb_obs, 12'hA3C);
        end
        pixel();
        n_checks++;
        if (rgb_obs !== 12'h124) begin
            n_fail++;
            $display("[TB] FAIL hold_second_edge: got %h expected %h", rgb_obs, 12'h124);
        end
    endtask

    task automatic test_reset_midline();
        char_pxl = 5'h00;
        obj_pxl  = 5'h05;
        gfx_en   = 3'b111;
        pixel();
        pixel();
        n_checks++;
        if (rgb_obs !== 12'hA3C) begin
            n_fail++;
            $display("[TB] FAIL midline_pre_rgb: got %h expected %h", rgb_obs, 12'hA3C);
        end
        cpu_addr = 9'h085;
        step();
        n_checks++;
        if (cpu_din !== 8'hA3) begin
            n_fail++;
            $display("[TB] FAIL midline_pre_cpu: got %h expected a3", cpu_din);
        end
        rst_n = 1'b0;
        step();
        n_checks++;
        if (rgb_obs !== 12'h000) begin
            n_fail++;
            $display("[TB] FAIL midline_rst_rgb: got %h expected %h", rgb_obs, 12'h000);
        end
        n_checks++;
        if ({LHBL_dly, LVBL_dly} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL midline_rst_dly: got %b expected 00", {LHBL_dly, LVBL_dly});
        end
        n_checks++;
        if (cpu_din !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL midline_rst_cpu: got %h expected 00", cpu_din);
        end
        rst_n = 1'b1;
        pixel();
        n_checks++;
        if (rgb_obs !== 12'h000) begin
            n_fail++;
            $display("[TB] FAIL midline_first_edge: got %h expected %h", rgb_obs, 12'h000);
        end
        pixel();
        n_checks++;
        if (rgb_obs !== 12'hA3C) begin
            n_fail++;
            $display("[TB] FAIL midline_second_edge: got %h expected %h", rgb_obs, 12'hA3C);
        end
        n_checks++;
        if (cpu_din !== 8'hA3) begin
            n_fail++;
            $display("[TB] FAIL midline_palette_kept: got %h expected a3", cpu_din);
        end
    endtask

    initial begin
        test_reset();
        load_palette();
        test_cpu_readback();
        test_priority();
        test_blanking();
        test_hold();
        test_reset_midline();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
